// File: rtl/pingpong_frame_sched_pkg.sv
// pingpong_pkg: types and constants shared by the ping-pong frame scheduler.
//   bank_state_e   - per-bank ownership state (FREE, FILLING, FULL, READING)
//   BANK_BITS      - width of a bank select (two banks -> 1 bit)
//   DROP_STALL     - DROP_MODE value: writer waits when no bank is free
//   DROP_OVERWRITE - DROP_MODE value: writer overwrites the oldest unread frame
package pingpong_pkg;

    localparam int BANK_BITS      = 1;
    localparam int DROP_STALL     = 0;
    localparam int DROP_OVERWRITE = 1;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_e;

endpackage

// File: rtl/pingpong_frame_sched_if.sv
// pingpong_frame_sched_if: bundle between the scheduler and the writer/reader side.
//   master : drives clear, wr_done, rd_done, wr_addr, rd_addr
//   slave  : the scheduler; drives BRAM addresses, writer gate, reader launch,
//            counters and the per-bank debug state
//
// Pulse semantics: wr_done, rd_done and rd_start are single-cycle event strobes
// with no back-pressure. An event is taken on the rising aclk edge where its strobe
// is high; wr_done is ignored while wr_run_en is low and rd_done is ignored while
// rd_active is low. rd_start marks the first cycle the reader owns rd_bank.
interface pingpong_frame_sched_if #(
    parameter int ADDR_W = 17,
    parameter int CNT_W  = 16
);
    import pingpong_pkg::*;

    logic                        clear;
    logic                        wr_done;
    logic                        rd_done;
    logic [ADDR_W-1:0]           wr_addr;
    logic [ADDR_W-1:0]           rd_addr;
    logic [ADDR_W:0]             bram_addra;
    logic [ADDR_W:0]             bram_addrb;
    logic                        wr_run_en;
    logic                        rd_start;
    logic                        rd_active;
    logic [BANK_BITS-1:0]        wr_bank;
    logic [BANK_BITS-1:0]        rd_bank;
    logic [CNT_W-1:0]            frames_out;
    logic [CNT_W-1:0]            frames_dropped;
    bank_state_e                 bank_state0;
    bank_state_e                 bank_state1;

    modport master (
        output clear, wr_done, rd_done, wr_addr, rd_addr,
        input  bram_addra, bram_addrb, wr_run_en, rd_start, rd_active,
               wr_bank, rd_bank, frames_out, frames_dropped, bank_state0, bank_state1
    );

    modport slave (
        input  clear, wr_done, rd_done, wr_addr, rd_addr,
        output bram_addra, bram_addrb, wr_run_en, rd_start, rd_active,
               wr_bank, rd_bank, frames_out, frames_dropped, bank_state0, bank_state1
    );

endinterface

// File: rtl/pingpong_frame_sched_sat_counter.sv
// sat_counter: event counter with synchronous clear.
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - synchronous clear (wins over inc)
//   inc       - count one event this cycle
//   count     - current value; wraps at 2^CNT_W, or holds at all-ones when SATURATE
module sat_counter #(
    parameter int CNT_W    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(SATURATE && (&count))) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pingpong_frame_sched.sv
// pingpong_frame_sched: double-buffer scheduler splitting one BRAM into two frame
// banks (address MSB = bank). The writer fills one bank while the reader streams
// the other; ownership moves on wr_done / rd_done.
//   aclk, areset - clock, asynchronous active-high reset
//   bus (slave)  - clear/wr_done/rd_done/addresses in; BRAM addresses, wr_run_en,
//                  rd_start, rd_active, bank selects, counters, bank debug state out
module pingpong_frame_sched
    import pingpong_pkg::*;
#(
    parameter int ADDR_W    = 17,
    parameter int DROP_MODE = DROP_STALL,
    parameter int CNT_W     = 16
) (
    input logic                   aclk,
    input logic                   areset,
    pingpong_frame_sched_if.slave bus
);

    bank_state_e          st_q [2];
    bank_state_e          st_n [2];
    logic [BANK_BITS-1:0] wr_bank_q, wr_bank_n;
    logic [BANK_BITS-1:0] rd_bank_q, rd_bank_n;
    logic [BANK_BITS-1:0] wr_other, free_bank, launch_bank;
    logic                 run_q, run_n;
    logic                 active_q, active_n;
    logic                 start_q, start_n;
    logic                 wr_ev, rd_ev, launch_ok;
    logic                 inc_out, inc_drop;

    // Events are resolved in order: read release, write completion, writer
    // re-homing, reader launch. Each later step sees the earlier results, which is
    // what gives the one-cycle wr_done -> rd_start latency and lets a simultaneous
    // wr_done/rd_done hand the freed bank straight to the writer.
    always_comb begin
        st_n        = st_q;
        wr_bank_n   = wr_bank_q;
        rd_bank_n   = rd_bank_q;
        run_n       = run_q;
        active_n    = active_q;
        start_n     = 1'b0;
        inc_out     = 1'b0;
        inc_drop    = 1'b0;
        free_bank   = '0;
        launch_bank = '0;
        launch_ok   = 1'b0;
        wr_other    = ~wr_bank_q;
        wr_ev       = bus.wr_done & run_q;
        rd_ev       = bus.rd_done & active_q;

        if (rd_ev) begin
            st_n[rd_bank_q] = FREE;
            active_n        = 1'b0;
            inc_out         = 1'b1;
        end

        if (wr_ev) begin
            // In overwrite mode the writer may be recirculating inside a bank that
            // already holds an unread frame; completing over it loses that frame.
            if (st_q[wr_bank_q] == FULL) begin
                inc_drop = 1'b1;
            end
            st_n[wr_bank_q] = FULL;
            if (st_n[wr_other] == FREE) begin
                st_n[wr_other] = FILLING;
                wr_bank_n      = wr_other;
            end else if (DROP_MODE == DROP_OVERWRITE && st_n[wr_other] == FULL) begin
                st_n[wr_other] = FILLING;
                wr_bank_n      = wr_other;
                inc_drop       = 1'b1;
            end else if (DROP_MODE == DROP_STALL) begin
                run_n = 1'b0;
            end
            // Otherwise (overwrite mode, other bank READING): the reading bank is
            // untouchable, so the writer keeps going in the bank it just completed.
        end

        // A writer without a FILLING bank (stalled, or recirculating over a FULL
        // bank) takes any bank that has just become free.
        if (st_n[0] != FILLING && st_n[1] != FILLING &&
            (st_n[0] == FREE || st_n[1] == FREE)) begin
            free_bank       = (st_n[0] == FREE) ? 1'b0 : 1'b1;
            st_n[free_bank] = FILLING;
            wr_bank_n       = free_bank;
            run_n           = 1'b1;
        end

        // Reader launch prefers the bank the writer is not on.
        if (!active_n) begin
            if (st_n[~wr_bank_n] == FULL) begin
                launch_ok   = 1'b1;
                launch_bank = ~wr_bank_n;
            end else if (st_n[wr_bank_n] == FULL) begin
                launch_ok   = 1'b1;
                launch_bank = wr_bank_n;
            end
            if (launch_ok) begin
                st_n[launch_bank] = READING;
                rd_bank_n         = launch_bank;
                active_n          = 1'b1;
                start_n           = 1'b1;
            end
        end

        if (bus.clear) begin
            st_n[0]   = FILLING;
            st_n[1]   = FREE;
            wr_bank_n = '0;
            rd_bank_n = '0;
            run_n     = 1'b1;
            active_n  = 1'b0;
            start_n   = 1'b0;
            inc_out   = 1'b0;
            inc_drop  = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            st_q[0]   <= FILLING;
            st_q[1]   <= FREE;
            wr_bank_q <= '0;
            rd_bank_q <= '0;
            run_q     <= 1'b1;
            active_q  <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            st_q      <= st_n;
            wr_bank_q <= wr_bank_n;
            rd_bank_q <= rd_bank_n;
            run_q     <= run_n;
            active_q  <= active_n;
            start_q   <= start_n;
        end
    end

    sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b0)) u_frames_out (
        .clk   (aclk),
        .rst   (areset),
        .clr   (bus.clear),
        .inc   (inc_out),
        .count (bus.frames_out)
    );

    sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_frames_dropped (
        .clk   (aclk),
        .rst   (areset),
        .clr   (bus.clear),
        .inc   (inc_drop),
        .count (bus.frames_dropped)
    );

    assign bus.bram_addra  = {wr_bank_q, bus.wr_addr};
    assign bus.bram_addrb  = {rd_bank_q, bus.rd_addr};
    assign bus.wr_run_en   = run_q;
    assign bus.rd_active   = active_q;
    assign bus.wr_bank     = wr_bank_q;
    assign bus.rd_bank     = rd_bank_q;
    // A launch pulse that would coincide with a soft reset is suppressed, so the
    // reader never starts on a bank that clear is about to reclaim.
    assign bus.rd_start    = start_q & ~bus.clear;
    assign bus.bank_state0 = st_q[0];
    assign bus.bank_state1 = st_q[1];

endmodule

// File: tb/tb_pingpong_frame_sched.sv
module tb_pingpong_frame_sched;
  import pingpong_pkg::*;

  localparam int ADDR_W = 17;
  localparam int CNT_W  = 16;
  localparam int N_FRAMES = 1000;

  logic aclk;
  logic areset;
  logic clear;
  logic wr_done;
  logic rd_done;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  int n_cmp;
  int n_fail;

  pingpong_frame_sched_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) if0 ();
  pingpong_frame_sched_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) if1 ();

  assign if0.clear = clear;
  assign if0.wr_done = wr_done;
  assign if0.rd_done = rd_done;
  assign if0.wr_addr = wr_addr;
  assign if0.rd_addr = rd_addr;
  assign if1.clear = clear;
  assign if1.wr_done = wr_done;
  assign if1.rd_done = rd_done;
  assign if1.wr_addr = wr_addr;
  assign if1.rd_addr = rd_addr;

  pingpong_frame_sched #(.ADDR_W(ADDR_W), .DROP_MODE(DROP_STALL), .CNT_W(CNT_W)) dut0 (
    .aclk(aclk), .areset(areset), .bus(if0.slave));
  pingpong_frame_sched #(.ADDR_W(ADDR_W), .DROP_MODE(DROP_OVERWRITE), .CNT_W(CNT_W)) dut1 (
    .aclk(aclk), .areset(areset), .bus(if1.slave));

  // ---------------- clock / reset ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // flags = {wr_run_en, rd_active, rd_start, wr_bank, rd_bank}
  function automatic logic [4:0] flags0();
    return {if0.wr_run_en, if0.rd_active, if0.rd_start, if0.wr_bank, if0.rd_bank};
  endfunction

  function automatic logic [4:0] flags1();
    return {if1.wr_run_en, if1.rd_active, if1.rd_start, if1.wr_bank, if1.rd_bank};
  endfunction

  // ---------------- driver tasks ----------------
  // Entered at a negedge; returns at the next negedge, after the DUT sampled.
  task automatic step(input logic w, input logic r);
    wr_done = w;
    rd_done = r;
    @(negedge aclk);
    wr_done = 1'b0;
    rd_done = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge aclk);
    clear = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    wr_addr = 17'($urandom_range(0, 131071));
    rd_addr = 17'($urandom_range(0, 131071));
    #1;
    n_cmp++; if (flags0() !== 5'b10000) begin n_fail++;
      $display("FAIL reset_flags0: got %b want %b", flags0(), 5'b10000); end
    n_cmp++; if (flags1() !== 5'b10000) begin n_fail++;
      $display("FAIL reset_flags1: got %b want %b", flags1(), 5'b10000); end
    n_cmp++; if ({if0.frames_out, if0.frames_dropped} !== 32'd0) begin n_fail++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", if0.frames_out, if0.frames_dropped); end
    n_cmp++; if ({if0.bank_state1, if0.bank_state0} !== {FREE, FILLING}) begin n_fail++;
      $display("FAIL reset_banks: got %0d/%0d want %0d/%0d", if0.bank_state1, if0.bank_state0, FREE, FILLING); end
    n_cmp++; if (if0.bram_addra !== {1'b0, wr_addr}) begin n_fail++;
      $display("FAIL reset_addra: got %h want %h", if0.bram_addra, {1'b0, wr_addr}); end
    n_cmp++; if (if0.bram_addrb !== {1'b0, rd_addr}) begin n_fail++;
      $display("FAIL reset_addrb: got %h want %h", if0.bram_addrb, {1'b0, rd_addr}); end
  endtask

  task automatic test_first_frame();
    do_clear();
    step(1'b1, 1'b0);
    n_cmp++; if (flags0() !== 5'b11110) begin n_fail++;
      $display("FAIL first_launch0: got %b want %b", flags0(), 5'b11110); end
    n_cmp++; if (flags1() !== 5'b11110) begin n_fail++;
      $display("FAIL first_launch1: got %b want %b", flags1(), 5'b11110); end
    n_cmp++; if (if0.bram_addra[ADDR_W] !== 1'b1) begin n_fail++;
      $display("FAIL first_addra_msb: got %b want 1", if0.bram_addra[ADDR_W]); end
    step(1'b0, 1'b0);
    n_cmp++; if (flags0() !== 5'b11010) begin n_fail++;
      $display("FAIL first_pulse_width: got %b want %b", flags0(), 5'b11010); end
  endtask

  task automatic test_stall();
    do_clear();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_cmp++; if (flags0() !== 5'b01010) begin n_fail++;
      $display("FAIL stall_enter: got %b want %b", flags0(), 5'b01010); end
    step(1'b1, 1'b0);
    n_cmp++; if (flags0() !== 5'b01010) begin n_fail++;
      $display("FAIL stall_wr_ignored: got %b want %b", flags0(), 5'b01010); end
    n_cmp++; if ({if0.bank_state1, if0.bank_state0} !== {FULL, READING}) begin n_fail++;
      $display("FAIL stall_banks: got %0d/%0d want %0d/%0d", if0.bank_state1, if0.bank_state0, FULL, READING); end
    step(1'b0, 1'b1);
    n_cmp++; if (flags0() !== 5'b11101) begin n_fail++;
      $display("FAIL stall_release: got %b want %b", flags0(), 5'b11101); end
    n_cmp++; if ({if0.frames_out, if0.frames_dropped} !== {16'd1, 16'd0}) begin n_fail++;
      $display("FAIL stall_counters: got %0d/%0d want 1/0", if0.frames_out, if0.frames_dropped); end
  endtask

  task automatic test_drop();
    do_clear();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_cmp++; if (flags1() !== 5'b11010 || if1.frames_dropped !== 16'd0) begin n_fail++;
      $display("FAIL drop_second: got %b/%0d want %b/0", flags1(), if1.frames_dropped, 5'b11010); end
    step(1'b1, 1'b0);
    n_cmp++; if (if1.frames_dropped !== 16'd1) begin n_fail++;
      $display("FAIL drop_count: got %0d want 1", if1.frames_dropped); end
    n_cmp++; if (flags1() !== 5'b11010) begin n_fail++;
      $display("FAIL drop_no_stall: got %b want %b", flags1(), 5'b11010); end
    n_cmp++; if (if1.bank_state0 !== READING) begin n_fail++;
      $display("FAIL drop_reading_kept: got %0d want %0d", if1.bank_state0, READING); end
    step(1'b0, 1'b1);
    n_cmp++; if (flags1() !== 5'b11101) begin n_fail++;
      $display("FAIL drop_newest_read: got %b want %b", flags1(), 5'b11101); end
    n_cmp++; if ({if1.frames_out, if1.frames_dropped} !== {16'd1, 16'd1}) begin n_fail++;
      $display("FAIL drop_counters: got %0d/%0d want 1/1", if1.frames_out, if1.frames_dropped); end
  endtask

  task automatic test_simultaneous();
    do_clear();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    n_cmp++; if (flags0() !== 5'b11101) begin n_fail++;
      $display("FAIL simul_flags0: got %b want %b", flags0(), 5'b11101); end
    n_cmp++; if (flags1() !== 5'b11101) begin n_fail++;
      $display("FAIL simul_flags1: got %b want %b", flags1(), 5'b11101); end
    n_cmp++; if ({if0.frames_out, if0.frames_dropped} !== {16'd1, 16'd0}) begin n_fail++;
      $display("FAIL simul_counters: got %0d/%0d want 1/0", if0.frames_out, if0.frames_dropped); end
  endtask

  task automatic test_spurious();
    do_clear();
    step(1'b0, 1'b1);
    n_cmp++; if (flags0() !== 5'b10000) begin n_fail++;
      $display("FAIL spurious_flags: got %b want %b", flags0(), 5'b10000); end
    n_cmp++; if ({if0.frames_out, if0.frames_dropped} !== 32'd0) begin n_fail++;
      $display("FAIL spurious_counters: got %0d/%0d want 0/0", if0.frames_out, if0.frames_dropped); end
    n_cmp++; if ({if0.bank_state1, if0.bank_state0} !== {FREE, FILLING}) begin n_fail++;
      $display("FAIL spurious_banks: got %0d/%0d want %0d/%0d", if0.bank_state1, if0.bank_state0, FREE, FILLING); end
  endtask

  task automatic test_async_reset();
    do_clear();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    #2 areset = 1'b1;
    #1;
    n_cmp++; if (flags0() !== 5'b10000) begin n_fail++;
      $display("FAIL areset_flags: got %b want %b", flags0(), 5'b10000); end
    n_cmp++; if (if0.frames_out !== 16'd0) begin n_fail++;
      $display("FAIL areset_frames_out: got %0d want 0", if0.frames_out); end
    @(negedge aclk);
    areset = 1'b0;
    n_cmp++; if ({if0.bank_state1, if0.bank_state0} !== {FREE, FILLING}) begin n_fail++;
      $display("FAIL areset_banks: got %0d/%0d want %0d/%0d", if0.bank_state1, if0.bank_state0, FREE, FILLING); end
  endtask

  task automatic test_clear();
    do_clear();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    clear = 1'b1;
    wr_done = 1'b1;
    rd_done = 1'b1;
    #1;
    n_cmp++; if (if0.rd_start !== 1'b0) begin n_fail++;
      $display("FAIL clear_start_masked: got %b want 0", if0.rd_start); end
    @(negedge aclk);
    clear = 1'b0;
    wr_done = 1'b0;
    rd_done = 1'b0;
    n_cmp++; if (flags0() !== 5'b10000) begin n_fail++;
      $display("FAIL clear_flags: got %b want %b", flags0(), 5'b10000); end
    n_cmp++; if ({if0.frames_out, if0.frames_dropped} !== 32'd0) begin n_fail++;
      $display("FAIL clear_counters: got %0d/%0d want 0/0", if0.frames_out, if0.frames_dropped); end
  endtask

  // Frame-level reference: frames complete in order into the bank the writer was
  // on, and the reader must consume them in the same order. The writer is blocked
  // exactly when two completed frames are still unreleased by the reader, and the
  // reader is busy whenever at least one completed frame is unreleased.
  task automatic test_random_frames();
    logic [0:0] exp_q[$];
    logic [0:0] exp_bank;
    int written, readn, starts, cyc, outstanding, wr_gap, rd_gap;
    logic busy, w, r;
    do_clear();
    written = 0; readn = 0; starts = 0; cyc = 0;
    wr_gap = $urandom_range(0, 4); rd_gap = 0; busy = 1'b0;
    while (readn < N_FRAMES && cyc < 40000) begin
      wr_addr = 17'($urandom_range(0, 131071));
      rd_addr = 17'($urandom_range(0, 131071));
      #1;
      outstanding = written - readn;
      n_cmp++; if (if0.wr_run_en !== (outstanding < 2)) begin n_fail++;
        $display("FAIL rand_run_en cyc %0d: got %b want %b", cyc, if0.wr_run_en, outstanding < 2); end
      n_cmp++; if (if0.rd_active !== (outstanding > 0)) begin n_fail++;
        $display("FAIL rand_rd_active cyc %0d: got %b want %b", cyc, if0.rd_active, outstanding > 0); end
      n_cmp++; if (if0.bank_state0 == FILLING && if0.bank_state1 == FILLING) begin n_fail++;
        $display("FAIL rand_two_filling cyc %0d: got both FILLING want at most one", cyc); end
      n_cmp++; if (if0.bram_addra !== {if0.wr_bank, wr_addr} || if0.bram_addrb !== {if0.rd_bank, rd_addr}) begin n_fail++;
        $display("FAIL rand_addr cyc %0d: got %h/%h want %h/%h", cyc, if0.bram_addra, if0.bram_addrb,
                 {if0.wr_bank, wr_addr}, {if0.rd_bank, rd_addr}); end
      if (if0.rd_start === 1'b1) begin
        starts++;
        n_cmp++;
        if (busy || exp_q.size() == 0) begin n_fail++;
          $display("FAIL rand_start_unexpected cyc %0d: got rd_start busy=%b queued=%0d want none", cyc, busy, exp_q.size());
        end else begin
          exp_bank = exp_q.pop_front();
          if (if0.rd_bank !== exp_bank) begin n_fail++;
            $display("FAIL rand_rd_bank cyc %0d: got %b want %b", cyc, if0.rd_bank, exp_bank); end
        end
        busy = 1'b1;
        rd_gap = $urandom_range(0, 6);
      end
      w = 1'b0;
      r = 1'b0;
      if (busy) begin
        if (rd_gap == 0) begin r = 1'b1; busy = 1'b0; readn++; end
        else rd_gap--;
      end
      if (written < N_FRAMES && if0.wr_run_en === 1'b1) begin
        if (wr_gap == 0) begin
          w = 1'b1;
          exp_q.push_back(if0.wr_bank);
          written++;
          wr_gap = $urandom_range(0, 5);
        end else begin
          wr_gap--;
        end
      end
      wr_done = w;
      rd_done = r;
      @(negedge aclk);
      wr_done = 1'b0;
      rd_done = 1'b0;
      cyc++;
    end
    n_cmp++; if (readn != N_FRAMES) begin n_fail++;
      $display("FAIL rand_timeout: got %0d frames read want %0d", readn, N_FRAMES); end
    n_cmp++; if (if0.frames_out !== 16'(N_FRAMES)) begin n_fail++;
      $display("FAIL rand_frames_out: got %0d want %0d", if0.frames_out, N_FRAMES); end
    n_cmp++; if (if0.frames_dropped !== 16'd0) begin n_fail++;
      $display("FAIL rand_frames_dropped: got %0d want 0", if0.frames_dropped); end
    n_cmp++; if (starts != readn) begin n_fail++;
      $display("FAIL rand_start_count: got %0d starts want %0d", starts, readn); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++;
      $display("FAIL rand_leftover: got %0d unread frames want 0", exp_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    areset = 1'b1;
    clear = 1'b0;
    wr_done = 1'b0;
    rd_done = 1'b0;
    wr_addr = '0;
    rd_addr = '0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    test_reset();
    test_first_frame();
    test_stall();
    test_drop();
    test_simultaneous();
    test_spurious();
    test_async_reset();
    test_clear();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
